// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
// IF stage plus IF/ID pipeline register for the RV32IM pipeline.
// Owns the fetch PC and drives a request/busywait instruction-memory read.
// It presents {INSTRUCTION, PC_OUT, PC_PLUS4, VALID} to the ID stage.
// A one-entry skid buffer captures a fetch that completes while ID is stalled.
// A redirect that arrives while a read is outstanding drains that read,
// because an issued request is never aborted.
// Optional build macro: FETCH_PERF_EN enables the FETCH_BUBBLES counter.
// When it is undefined, FETCH_BUBBLES is tied to zero.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_OUT,
    output logic [31:0] PC_PLUS4,
    output logic        VALID,
    output logic [31:0] FETCH_BUBBLES
);

    // Fetch controller states.
    // HOLD means the skid buffer is full.
    // DRAIN means an outstanding read will be thrown away.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Redirect addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    // Architectural state
    state_t      state_r;
    logic [31:0] pc_r;            // next fetch address, doubles as IMEM_ADDR
    logic        imem_read_r;
    logic [31:0] target_r;        // redirect target remembered while draining
    logic [31:0] skid_instr_r;
    logic [31:0] skid_pc_r;
    logic [31:0] if_instr_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_pc4_r;
    logic        if_valid_r;

    // Next-state values
    state_t      state_s;
    logic [31:0] pc_s;
    logic        imem_read_s;
    logic [31:0] target_s;
    logic [31:0] skid_instr_s;
    logic [31:0] skid_pc_s;
    logic [31:0] if_instr_s;
    logic [31:0] if_pc_s;
    logic [31:0] if_pc4_s;
    logic        if_valid_s;

    // IF/ID load selects
    logic        ld_bubble_s;
    logic        ld_mem_s;
    logic        ld_skid_s;
    logic        done_s;
    logic [31:0] redirect_s;
    logic [31:0] drain_tgt_s;

    // A transfer completes at an edge where a read is requested and memory is ready.
    assign done_s     = imem_read_r & ~IMEM_BUSYWAIT;
    assign redirect_s = align_word(BRANCH_TARGET);

    // Fetch control: PC sequencing, skid capture, drain bookkeeping.
    // Also selects what IF/ID loads.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        imem_read_s  = imem_read_r;
        target_s     = target_r;
        skid_instr_s = skid_instr_r;
        skid_pc_s    = skid_pc_r;
        ld_bubble_s  = 1'b0;
        ld_mem_s     = 1'b0;
        ld_skid_s    = 1'b0;
        drain_tgt_s  = target_r;

        case (state_r)
            ST_BOOT: begin
                // One idle cycle after reset before the first request.
                state_s     = ST_FETCH;
                imem_read_s = 1'b1;
            end

            ST_FETCH: begin
                if (BRANCH_TAKEN) begin
                    ld_bubble_s = 1'b1;
                    if (done_s) begin
                        // Fetched word is on the wrong path: drop it and redirect now.
                        pc_s = redirect_s;
                    end else begin
                        // Read still in flight: remember target, wait it out.
                        target_s = redirect_s;
                        state_s  = ST_DRAIN;
                    end
                end else if (done_s) begin
                    pc_s = pc_inc(pc_r);
                    if (STALL) begin
                        // ID cannot accept: park the word in the skid buffer.
                        skid_instr_s = IMEM_READDATA;
                        skid_pc_s    = pc_r;
                        state_s      = ST_HOLD;
                        imem_read_s  = 1'b0;
                    end else begin
                        ld_mem_s = 1'b1;
                    end
                end else if (!STALL) begin
                    ld_bubble_s = 1'b1;
                end else begin
                    // Stalled with nothing new: IF/ID keeps its entry.
                    ld_bubble_s = 1'b0;
                end
            end

            ST_HOLD: begin
                if (BRANCH_TAKEN) begin
                    // Redirect wins over stall; the skid entry is wrong-path.
                    ld_bubble_s = 1'b1;
                    pc_s        = redirect_s;
                    state_s     = ST_FETCH;
                    imem_read_s = 1'b1;
                end else if (!STALL) begin
                    ld_skid_s   = 1'b1;
                    state_s     = ST_FETCH;
                    imem_read_s = 1'b1;
                end else begin
                    // Still stalled: skid and IF/ID both hold.
                    state_s = ST_HOLD;
                end
            end

            ST_DRAIN: begin
                // A newer redirect replaces the remembered one.
                if (BRANCH_TAKEN) begin
                    drain_tgt_s = redirect_s;
                end else begin
                    drain_tgt_s = target_r;
                end
                target_s = drain_tgt_s;
                if (done_s) begin
                    pc_s    = drain_tgt_s;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DRAIN;
                end
                if (BRANCH_TAKEN || !STALL) begin
                    ld_bubble_s = 1'b1;
                end else begin
                    ld_bubble_s = 1'b0;
                end
            end

            default: begin
                state_s     = ST_BOOT;
                imem_read_s = 1'b0;
            end
        endcase
    end

    // IF/ID next value: bubble, fresh memory word, skid entry, or hold.
    always_comb begin
        if_instr_s = if_instr_r;
        if_pc_s    = if_pc_r;
        if_pc4_s   = if_pc4_r;
        if_valid_s = if_valid_r;
        if (ld_bubble_s) begin
            if_instr_s = NOP_INSTR;
            if_valid_s = 1'b0;
        end else if (ld_mem_s) begin
            if_instr_s = IMEM_READDATA;
            if_pc_s    = pc_r;
            if_pc4_s   = pc_inc(pc_r);
            if_valid_s = 1'b1;
        end else if (ld_skid_s) begin
            if_instr_s = skid_instr_r;
            if_pc_s    = skid_pc_r;
            if_pc4_s   = pc_inc(skid_pc_r);
            if_valid_s = 1'b1;
        end else begin
            if_valid_s = if_valid_r;
        end
    end

    // State, PC, handshake and IF/ID registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC;
            imem_read_r  <= 1'b0;
            target_r     <= RESET_PC;
            skid_instr_r <= NOP_INSTR;
            skid_pc_r    <= RESET_PC;
            if_instr_r   <= NOP_INSTR;
            if_pc_r      <= RESET_PC;
            if_pc4_r     <= pc_inc(RESET_PC);
            if_valid_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            imem_read_r  <= imem_read_s;
            target_r     <= target_s;
            skid_instr_r <= skid_instr_s;
            skid_pc_r    <= skid_pc_s;
            if_instr_r   <= if_instr_s;
            if_pc_r      <= if_pc_s;
            if_pc4_r     <= if_pc4_s;
            if_valid_r   <= if_valid_s;
        end
    end

    assign IMEM_READ   = imem_read_r;
    assign IMEM_ADDR   = pc_r;
    assign INSTRUCTION = if_instr_r;
    assign PC_OUT      = if_pc_r;
    assign PC_PLUS4    = if_pc4_r;
    assign VALID       = if_valid_r;

`ifdef FETCH_PERF_EN
    logic [31:0] bubbles_r;

    // Count every bubble written into IF/ID after boot, saturating at all-ones.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bubbles_r <= 32'h0000_0000;
        end else if (ld_bubble_s && (bubbles_r != 32'hFFFF_FFFF)) begin
            bubbles_r <= bubbles_r + 32'd1;
        end else begin
            bubbles_r <= bubbles_r;
        end
    end

    assign FETCH_BUBBLES = bubbles_r;
`else
    assign FETCH_BUBBLES = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage.
// A reference model predicts the outputs at each edge.
// Each prediction is queued, then popped and compared on the following falling edge.
module tb_instruction_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = 32'h0;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_READDATA;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC_OUT;
    logic [31:0] PC_PLUS4;
    logic        VALID;
    logic [31:0] FETCH_BUBBLES;

    int total = 0;
    int bad   = 0;

    instruction_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL),
        .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
        .IMEM_READ(IMEM_READ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .INSTRUCTION(INSTRUCTION), .PC_OUT(PC_OUT), .PC_PLUS4(PC_PLUS4),
        .VALID(VALID), .FETCH_BUBBLES(FETCH_BUBBLES)
    );

    always #5 CLK = ~CLK;

    // Memory contents depend on the address, but differ from it.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign IMEM_READDATA = mem_word(IMEM_ADDR);

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ins;
        logic        chk_pc;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] bub;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the fetch pointer and the ID-stage entry.
    // The parked-word queue and pending-redirect queue are empty or hold one entry.
    bit          m_booted;
    bit          m_valid;
    bit          m_pc_known;
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] m_bub;
    logic [31:0] m_skid[$];
    logic [31:0] m_redir[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.rd     = m_booted && (m_skid.size() == 0);
        e.addr   = m_pc;
        e.vld    = m_valid;
        e.ins    = m_valid ? mem_word(m_ifpc) : NOP;
        e.chk_pc = m_pc_known;
        e.pc     = m_ifpc;
        e.pc4    = m_ifpc + 32'd4;
`ifdef FETCH_PERF_EN
        e.bub    = m_bub;
`else
        e.bub    = 32'h0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_booted   = 0;
        m_valid    = 0;
        m_pc_known = 1;
        m_pc       = RST_PC;
        m_ifpc     = RST_PC;
        m_bub      = 32'h0;
        m_skid.delete();
        m_redir.delete();
    endtask

    task automatic model_step();
        bit          reading;
        bit          done;
        bit          bubble;
        logic [31:0] tgt;
        reading = m_booted && (m_skid.size() == 0);
        done    = reading && !IMEM_BUSYWAIT;
        tgt     = BRANCH_TARGET & 32'hFFFF_FFFC;
        bubble  = 0;
        if (!m_booted) begin
            m_booted = 1;
        end else if (m_skid.size() != 0) begin
            if (BRANCH_TAKEN) begin
                m_skid.delete();
                m_pc   = tgt;
                bubble = 1;
            end else if (!STALL) begin
                m_ifpc     = m_skid.pop_front();
                m_valid    = 1;
                m_pc_known = 1;
            end
        end else if (m_redir.size() != 0) begin
            if (BRANCH_TAKEN) m_redir[0] = tgt;
            if (done) m_pc = m_redir.pop_front();
            if (BRANCH_TAKEN || !STALL) bubble = 1;
        end else begin
            if (BRANCH_TAKEN) begin
                if (done) m_pc = tgt;
                else m_redir.push_back(tgt);
                bubble = 1;
            end else if (done) begin
                if (STALL) begin
                    m_skid.push_back(m_pc);
                end else begin
                    m_ifpc     = m_pc;
                    m_valid    = 1;
                    m_pc_known = 1;
                end
                m_pc = m_pc + 32'd4;
            end else if (!STALL) begin
                bubble = 1;
            end
        end
        if (bubble) begin
            m_valid    = 0;
            m_pc_known = 0;
            if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
        end
    endtask

    // Advance the model at each edge and queue its prediction.
    always @(posedge CLK) begin
        if (RESET) model_reset();
        else model_step();
        exp_q.push_back(snapshot());
    end

    // Compare the DUT against the oldest prediction on each falling edge.
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("imem_read", {31'd0, IMEM_READ}, {31'd0, e.rd});
            if (e.rd) check("imem_addr", IMEM_ADDR, e.addr);
            check("valid", {31'd0, VALID}, {31'd0, e.vld});
            check("instruction", INSTRUCTION, e.ins);
            if (e.chk_pc) begin
                check("pc_out", PC_OUT, e.pc);
                check("pc_plus4", PC_PLUS4, e.pc4);
            end
            check("fetch_bubbles", FETCH_BUBBLES, e.bub);
        end
    end

    task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic bw);
        @(negedge CLK);
        #1;
        STALL         = s;
        BRANCH_TAKEN  = b;
        BRANCH_TARGET = t;
        IMEM_BUSYWAIT = bw;
    endtask

    initial begin
        logic [31:0] rt;
        repeat (2) @(negedge CLK);
        #1;
        RESET = 1'b0;
        // Boot, then fetch from 0x0 and 0x4.
        repeat (2) drive(1'b0, 1'b0, 32'h0, 1'b0);
        // Memory is busy for three cycles on the 0x8 fetch.
        repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        // Stall for two cycles while the 0xC fetch completes.
        repeat (2) drive(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 32'h0, 1'b0);
        // Redirect to 0x103 while busy; the stale read drains.
        drive(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 32'h0, 1'b0);
        // Stall into HOLD, then redirect and stall together toward the wrap point.
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0);
        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0) rt = $urandom;
            else rt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, rt,
                  $urandom_range(0, 2) == 0);
        end
        // Reach DRAIN, then assert reset between edges.
        repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        RESET = 1'b1;
        #1;
        check("rst_imem_read", {31'd0, IMEM_READ}, 32'd0);
        check("rst_imem_addr", IMEM_ADDR, RST_PC);
        check("rst_valid", {31'd0, VALID}, 32'd0);
        check("rst_instruction", INSTRUCTION, NOP);
        check("rst_pc_out", PC_OUT, RST_PC);
        check("rst_pc_plus4", PC_PLUS4, RST_PC + 32'd4);
        check("rst_fetch_bubbles", FETCH_BUBBLES, 32'd0);
        repeat (2) @(negedge CLK);
        #1;
        RESET = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        repeat (6) drive(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge CLK);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
IF stage plus IF/ID pipeline register of the RV32IM pipeline. Owns the PC and drives the instruction-memory read handshake. Presents the fetched INSTRUCTION, its PC and PC+4 to the ID stage (decode, register file, sign extend unit). Handles stall from the hazard unit and redirect from the branch/jump resolution logic.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) placed in IF/ID when VALID=0

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  asynchronous, active-high reset
STALL  in  1  hazard unit: hold IF/ID and do not consume a new instruction
BRANCH_TAKEN  in  1  redirect request from EX
BRANCH_TARGET  in  32  redirect address; bits [1:0] ignored and forced to 00
IMEM_READ  out  1  instruction memory read request
IMEM_ADDR  out  32  instruction memory address (word aligned)
IMEM_READDATA  in  32  instruction word
IMEM_BUSYWAIT  in  1  memory not ready; transfer completes at an edge with IMEM_READ=1 and IMEM_BUSYWAIT=0
INSTRUCTION  out  32  IF/ID instruction to ID stage
PC_OUT  out  32  IF/ID PC of INSTRUCTION
PC_PLUS4  out  32  IF/ID PC_OUT+4
VALID  out  1  IF/ID holds a real instruction
FETCH_BUBBLES  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset (async, immediate): PC=RESET_PC; state=BOOT; skid buffer empty; IMEM_READ=0; IMEM_ADDR=RESET_PC; INSTRUCTION=NOP_INSTR; PC_OUT=RESET_PC; PC_PLUS4=RESET_PC+4; VALID=0; FETCH_BUBBLES=0.
- Handshake: while IMEM_READ=1, IMEM_ADDR stays stable until completion. IMEM_READDATA is sampled at the completion edge. An issued request is never aborted.
- BOOT: IMEM_READ=0 for one cycle, then go to FETCH.
- FETCH: IMEM_READ=1, IMEM_ADDR=PC.
  - Completion with BRANCH_TAKEN=0, STALL=0: IF/ID <- {data, PC, PC+4}, VALID=1, PC+=4, stay in FETCH.
  - Completion with BRANCH_TAKEN=0, STALL=1: data and PC go to the one-entry skid buffer, PC+=4, IF/ID unchanged, go to HOLD.
  - Completion with BRANCH_TAKEN=1: discard data, PC=target, stay in FETCH.
  - BRANCH_TAKEN=1 with IMEM_BUSYWAIT=1: latch target, go to DRAIN.
  - No completion, STALL=0: IF/ID <- bubble (VALID=0, INSTRUCTION=NOP_INSTR).
  - No completion, STALL=1: IF/ID holds.
- HOLD: IMEM_READ=0.
  - STALL=0: IF/ID <- skid, VALID=1, skid empties, go to FETCH.
  - BRANCH_TAKEN=1 (overrides STALL): skid cleared, PC=target, go to FETCH.
- DRAIN: IMEM_READ=1 on the old address until completion; data is discarded. Then PC=latched target and go to FETCH. A new BRANCH_TAKEN during DRAIN overwrites the latched target.
- BRANCH_TAKEN always has priority over STALL. At any edge where it is 1, IF/ID <- bubble.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000, and PC_PLUS4 wraps the same way.
- Steady-state throughput with IMEM_BUSYWAIT=0 is one instruction per cycle. Latency from IMEM_ADDR to INSTRUCTION is one edge.

Optional Feature:
FETCH_PERF_EN
- Defined: FETCH_BUBBLES increments by 1 at every rising edge after BOOT where the IF/ID register is loaded with a bubble. It saturates at 32'hFFFFFFFF and clears only on RESET.
- Undefined: the counter logic is absent and FETCH_BUBBLES is tied to 0.

Test Plan:
- RESET_PC=0, BUSYWAIT=0, memory word=address: release RESET -> one BOOT cycle with IMEM_READ=0; then PC_OUT=0,4,8 with VALID=1 on consecutive edges, and INSTRUCTION equals PC_OUT.
- BUSYWAIT high for 3 cycles on address 0x8 -> IMEM_ADDR held at 0x8 and IMEM_READ=1 throughout; 3 bubbles (VALID=0, INSTRUCTION=0x13); FETCH_BUBBLES=3 with FETCH_PERF_EN.
- STALL=1 for 2 cycles while the 0xC fetch completes -> IF/ID holds the 0x8 entry; skid holds 0xC; after STALL drops, PC_OUT=0xC then 0x10, with no lost or duplicated instruction.
- BRANCH_TAKEN with target 0x103 while BUSYWAIT=1 -> DRAIN; stale data is discarded; the next IMEM_ADDR is 0x100; VALID=0 until the 0x100 instruction loads.
- BRANCH_TAKEN and STALL both high in HOLD -> skid dropped; VALID=0; next fetch from target; PC wrap test: PC=0xFFFFFFFC gives PC_PLUS4=0 and next PC=0.
- RESET asserted mid-DRAIN -> outputs go to reset values without waiting for a clock edge; IMEM_READ=0 and the pending target is lost.
